apx_err_accum: RTL

Downstream error-statistics stage for the approximate integer adders (truncation and rounding BTA variants). Each cycle it can consume one result pair: an approximate adder output and the accurate adder output for the same operands. Over a programmable window of samples it accumulates the mismatch count, maximum absolute error and sum of absolute error. The NAB-sweep characterisation flow reads these statistics in place of per-sample file dumps.

---
 rtl/apx_err_accum.sv | 124 ++++++++++++
 1 files changed

// File: rtl/apx_err_accum.sv
// rtl/apx_err_accum.sv - windowed error statistics for approximate vs. accurate adder results
// Two-stage pipeline: stage 1 forms |apx-acc| and mismatch, stage 2 folds them into the stats.
module apx_err_accum #(
   parameter int WIDTH = 32,
   parameter int SUM_W = 48,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] win_len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] apx_c,
   input  logic [WIDTH-1:0] acc_c,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH-1:0] max_abs_err,
   output logic [SUM_W-1:0] sum_abs_err,
   output logic             sum_sat
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] win_q;
   logic [CNT_W-1:0] acc_q;
   logic             s1_valid;
   logic [WIDTH-1:0] s1_abs;
   logic             s1_ne;

   logic             accept;
   logic             start_ok;
   logic             last_accept;
   logic [WIDTH-1:0] abs_d;
   logic [SUM_W:0]   sum_ext;
   logic             sum_hit;

   assign accept      = in_valid && in_ready;
   assign start_ok    = start && (state_q == IDLE || state_q == DONE);
   assign last_accept = accept && ((acc_q + CNT_W'(1)) == win_q);
   assign abs_d       = (apx_c >= acc_c) ? (apx_c - acc_c) : (acc_c - apx_c);
   assign sum_ext     = {1'b0, sum_abs_err} + {{(SUM_W + 1 - WIDTH){1'b0}}, s1_abs};
   assign sum_hit     = sum_ext[SUM_W] || (&sum_ext[SUM_W-1:0]);

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (win_len == '0) ? DONE : RUN;
         end
         RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (last_accept) state_d = DRAIN;
         end
         DRAIN: begin
            // Only the final sample can be in flight here, and it retires on this edge.
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_d = (win_len == '0) ? DONE : RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_q       <= '0;
         acc_q       <= '0;
         s1_valid    <= 1'b0;
         s1_abs      <= '0;
         s1_ne       <= 1'b0;
         sample_cnt  <= '0;
         err_cnt     <= '0;
         max_abs_err <= '0;
         sum_abs_err <= '0;
         sum_sat     <= 1'b0;
      end else if (start_ok) begin
         win_q       <= win_len;
         acc_q       <= '0;
         s1_valid    <= 1'b0;
         s1_abs      <= '0;
         s1_ne       <= 1'b0;
         sample_cnt  <= '0;
         err_cnt     <= '0;
         max_abs_err <= '0;
         sum_abs_err <= '0;
         sum_sat     <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_abs <= abs_d;
            s1_ne  <= (apx_c != acc_c);
            acc_q  <= acc_q + CNT_W'(1);
         end
         if (s1_valid) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
            err_cnt    <= err_cnt + CNT_W'(s1_ne);
            if (s1_abs > max_abs_err) max_abs_err <= s1_abs;
            // Saturate at all-ones; landing exactly on all-ones also counts as saturated.
            sum_abs_err <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
            if (sum_hit) sum_sat <= 1'b1;
         end
      end
   end

endmodule
